mul_share_arbiter: RTL
======================

Name: mul_share_arbiter

Overview:
- Shares one synchronous 4x4 unsigned multiplier datapath among NREQ requesters.
- Each requester presents operands with a valid/ready handshake.
- A round-robin arbiter grants at most one request per cycle. The registered product returns on a single response channel with the requester ID and ready backpressure.
- Sits between the operand-producing clients and any downstream consumer of products.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OPW, 4, operand width in bits.
- CNTW, 16, width of the saturating completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*OPW  packed operand A; requester i uses bits [i*OPW +: OPW].
- req_b  in  NREQ*OPW  packed operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot (or zero) grant/accept.
- rsp_valid  out  1  product valid.
- rsp_data  out  2*OPW  unsigned product a*b.
- rsp_id  out  $clog2(NREQ)  index of the requester that owns rsp_data.
- rsp_ready  in  1  consumer accepts the response.
- op_count  out  CNTW  number of completed responses (rsp_valid && rsp_ready), saturating.

Behaviour:
- Reset: while rst_n=0, all of the following clear asynchronously:
  - rsp_valid=0, rsp_data=0, rsp_id=0;
  - round-robin pointer ptr=0;
  - op_count=0.
  - req_ready is 0 during reset.
- Reset mid-operation: a pending response is discarded. No replay occurs.
- can_issue = !rsp_valid || rsp_ready. This is combinational and allows back-to-back throughput.
- Arbitration (combinational):
  - If can_issue=0, req_ready is all zeros.
  - Otherwise, grant the first i with req_valid[i]=1, searching from ptr upward modulo NREQ.
  - req_ready[i] is 1 only for the granted i.
  - req_ready depends on req_valid (no ready-before-valid guarantee). Requesters must not make valid depend on ready.
- Transfer: a request transfers when req_valid[i] && req_ready[i]. On that edge:
  - rsp_data <= a_i*b_i (zero-extended to 2*OPW, no truncation);
  - rsp_id <= i;
  - rsp_valid <= 1;
  - ptr <= (i+1) mod NREQ.
- If no transfer occurs: ptr holds. If rsp_valid && rsp_ready, then rsp_valid <= 0; rsp_data and rsp_id hold their stale values.
- Latency: accepted at edge N gives rsp_valid=1 after edge N, i.e. the response is visible in the cycle following the accepting edge.
- Throughput: one result per cycle when rsp_ready=1 continuously.
- Backpressure: while rsp_valid=1 && rsp_ready=0:
  - rsp_data and rsp_id are stable;
  - no grants are issued;
  - ptr is frozen.
- Simultaneous events: in the same cycle as rsp_valid && rsp_ready, a new grant is allowed. The register reloads with the new product and rsp_valid stays 1.
- Requester rules: valid and operands must be held stable until ready. Dropping valid without ready is allowed and simply loses the slot. The block does not check this.
- op_count: increments by 1 on each rsp_valid && rsp_ready. It saturates at 2^CNTW-1 (no wrap).
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,..,NREQ-1,0,... No requester waits more than NREQ-1 grants.
- ptr wrap: if NREQ is not a power of two, ptr wraps from NREQ-1 to 0 explicitly.

Decomposition:
- Package mul_share_pkg:
  - constants OPW_DEF=4, NREQ_DEF=4, CNTW_DEF=16;
  - typedef operand_t (logic [OPW-1:0]);
  - typedef product_t (logic [2*OPW-1:0]).
- Sub-module rr_arbiter: parameter NREQ; inputs req[NREQ], ptr, en; outputs gnt one-hot and gnt_idx.
  - Purely combinational, with ptr kept in the parent.
- The parent holds the product/response register, ptr, and op_count.

Test Plan:
- Reset/idle: assert rst_n=0 mid-response with rsp_valid=1 and data 0x2D -> rsp_valid=0, rsp_data=0, op_count=0 immediately; req_ready=0 while in reset.
- Single request: req 2 valid, a=4'hF, b=4'hF, rsp_ready=1 -> req_ready=4'b0100 that cycle; next cycle rsp_valid=1, rsp_data=8'hE1, rsp_id=2; op_count=1.
- Round robin: all 4 valid, a_i=i+1, b_i=3, rsp_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp_data 3,6,9,12 repeating; no idle cycles.
- Backpressure: hold rsp_ready=0 for 3 cycles with req 1 (a=5, b=6) pending behind rsp_id=0 data=0x08 -> rsp_data stays 0x08, req_ready=0; on rsp_ready=1 the same cycle grants req 1; next cycle rsp_data=0x1E, rsp_id=1.
- Zero/boundary operands: a=0, b=4'hF -> 0x00; a=4'h8, b=4'h8 -> 0x40; with ptr=3 and only req 0 valid -> req 0 granted and ptr becomes 1.
- Counter saturation: CNTW=4, complete 20 responses -> op_count stops at 4'hF.

Source files
------------

// File: rtl/mul_share_arbiter_pkg.sv
// Shared constants, operand/product types and a ring-index helper for the
// shared-multiplier arbiter.
package mul_share_pkg;

  localparam int OPW_DEF  = 4;
  localparam int NREQ_DEF = 4;
  localparam int CNTW_DEF = 16;

  typedef logic [OPW_DEF-1:0]   operand_t;
  typedef logic [2*OPW_DEF-1:0] product_t;

  // Folds an index in [0, 2n) back onto the ring [0, n); works for any n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// modulo NREQ. The pointer itself lives in the parent.
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx
);

  int idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    if (en) begin
      // Walk the ring backwards so the closest hit to ptr is written last.
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = rr_wrap(int'(ptr) + k, NREQ);
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          gnt_idx  = IDXW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// One registered OPW x OPW unsigned multiplier shared by NREQ requesters via a
// round-robin grant, with a single backpressured response channel.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int OPW  = OPW_DEF,
  parameter  int CNTW = CNTW_DEF,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic              rsp_valid,
  output logic [2*OPW-1:0]  rsp_data,
  output logic [IDXW-1:0]   rsp_id,
  input  logic              rsp_ready,
  output logic [CNTW-1:0]   op_count
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [2*OPW-1:0] rsp_data_q,  rsp_data_d;
  logic [IDXW-1:0]  rsp_id_q,    rsp_id_d;
  logic [IDXW-1:0]  ptr_q,       ptr_d;
  logic [CNTW-1:0]  op_count_q,  op_count_d;

  logic             can_issue;
  logic             arb_en;
  logic [NREQ-1:0]  gnt;
  logic [IDXW-1:0]  gnt_idx;
  logic             fire;
  logic [OPW-1:0]   a_sel, b_sel;
  logic [2*OPW-1:0] product;

  // The output slot is free when empty or being drained this very cycle.
  assign can_issue = !rsp_valid_q || rsp_ready;
  // Holding grants off during reset keeps req_ready low while rst_n is low.
  assign arb_en    = can_issue && rst_n;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign fire = |gnt;

  always_comb begin
    a_sel   = req_a[gnt_idx*OPW +: OPW];
    b_sel   = req_b[gnt_idx*OPW +: OPW];
    product = {{OPW{1'b0}}, a_sel} * {{OPW{1'b0}}, b_sel};
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    op_count_d  = op_count_q;

    if (fire) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = product;
      rsp_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + IDXW'(1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (rsp_valid_q && rsp_ready && (op_count_q != '1)) begin
      op_count_d = op_count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
      op_count_q  <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignment so every flop samples
      // the pre-edge value of every other, independent of statement order.
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
      op_count_q  <= op_count_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;

endmodule
